grid_fill_engine: RTL

GRID_FILL_ENGINE -- requirements
Module: grid_fill_engine

---
 rtl/grid_pkg.sv | 20 ++
 rtl/grid_scan_ctr.sv | 65 ++++++
 rtl/grid_fill_engine.sv | 135 +++++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// Shared parameters and state encoding for the grid fill engine.
// Derived widths assume power-of-two grid dimensions.
package grid_pkg;

  localparam int GRID_W_DEF = 32;
  localparam int GRID_H_DEF = 32;
  localparam int CELL_W_DEF = 8;

  localparam int XW_DEF = $clog2(GRID_W_DEF);
  localparam int YW_DEF = $clog2(GRID_H_DEF);
  localparam int AW_DEF = XW_DEF + YW_DEF;
  localparam int NW_DEF = AW_DEF + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/grid_scan_ctr.sv
// Row-major x/y scan over a clipped rectangle.
// x wraps to the origin column at x_end and y steps.
module grid_scan_ctr #(
  parameter int XW = 5,
  parameter int YW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x_end,
  input  logic [YW-1:0] y_end,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic [XW-1:0] x_q, x_d, x0_q, x0_d, xe_q, xe_d;
  logic [YW-1:0] y_q, y_d, ye_q, ye_d;

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    x0_d = x0_q;
    xe_d = xe_q;
    ye_d = ye_q;
    if (load) begin
      x_d  = x0;
      y_d  = y0;
      x0_d = x0;
      xe_d = x_end;
      ye_d = y_end;
    end else if (advance) begin
      if (x_q == xe_q) begin
        x_d = x0_q;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q  <= '0;
      y_q  <= '0;
      x0_q <= '0;
      xe_q <= '0;
      ye_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      x0_q <= x0_d;
      xe_q <= xe_d;
      ye_q <= ye_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == xe_q) && (y_q == ye_q);

endmodule

// File: rtl/grid_fill_engine.sv
// Rectangle fill engine: clips a command to the grid and writes
// every covered cell to RAM, one handshaked write per cell.
module grid_fill_engine
  import grid_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int CELL_W = CELL_W_DEF,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int AW = XW + YW,
  localparam int NW = AW + 1
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [XW-1:0]     cmd_x0,
  input  logic [YW-1:0]     cmd_y0,
  input  logic [XW:0]       cmd_w,
  input  logic [YW:0]       cmd_h,
  input  logic [CELL_W-1:0] cmd_value,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [CELL_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              clipped,
  output logic [NW-1:0]     cells_written
);

  localparam logic [XW+1:0] XLIM = (XW+2)'(GRID_W);
  localparam logic [YW+1:0] YLIM = (YW+2)'(GRID_H);
  localparam logic [XW+1:0] XONE = (XW+2)'(1);
  localparam logic [YW+1:0] YONE = (YW+2)'(1);

  state_e            state_q, state_d;
  logic [CELL_W-1:0] value_q, value_d;
  logic              clipped_q, clipped_d;
  logic [NW-1:0]     cells_q, cells_d;

  logic [XW+1:0] x_sum, x_lim, x_em1;
  logic [YW+1:0] y_sum, y_lim, y_em1;
  logic          x_clip, y_clip, zero_sz, accept;
  logic          scan_load, scan_adv, scan_last;
  logic [XW-1:0] scan_x;
  logic [YW-1:0] scan_y;

  // Sums are one bit wider than the size fields so origin+size never wraps.
  always_comb begin
    x_sum  = {2'b00, cmd_x0} + {1'b0, cmd_w};
    y_sum  = {2'b00, cmd_y0} + {1'b0, cmd_h};
    x_clip = x_sum > XLIM;
    y_clip = y_sum > YLIM;
    x_lim  = x_clip ? XLIM : x_sum;
    y_lim  = y_clip ? YLIM : y_sum;
    x_em1  = x_lim - XONE;
    y_em1  = y_lim - YONE;
  end

  assign zero_sz   = (cmd_w == '0) || (cmd_h == '0);
  assign cmd_ready = (state_q == IDLE) && !ARESET;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    clipped_d = clipped_q;
    cells_d   = cells_q;
    scan_load = 1'b0;
    scan_adv  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          value_d   = cmd_value;
          clipped_d = x_clip || y_clip;
          cells_d   = '0;
          scan_load = 1'b1;
          state_d   = zero_sz ? DONE : FILL;
        end
      end
      FILL: begin
        if (mem_ready) begin
          scan_adv = 1'b1;
          cells_d  = cells_q + NW'(1);
          if (scan_last) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      value_q   <= '0;
      clipped_q <= 1'b0;
      cells_q   <= '0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      clipped_q <= clipped_d;
      cells_q   <= cells_d;
    end
  end

  grid_scan_ctr #(
    .XW(XW),
    .YW(YW)
  ) u_scan (
    .clk    (ACLK),
    .rst    (ARESET),
    .load   (scan_load),
    .advance(scan_adv),
    .x0     (cmd_x0),
    .y0     (cmd_y0),
    .x_end  (x_em1[XW-1:0]),
    .y_end  (y_em1[YW-1:0]),
    .x      (scan_x),
    .y      (scan_y),
    .last   (scan_last)
  );

  // Power-of-two width makes y*GRID_W + x a plain concatenation.
  assign mem_addr      = {scan_y, scan_x};
  assign mem_we        = (state_q == FILL);
  assign mem_wdata     = value_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign clipped       = clipped_q;
  assign cells_written = cells_q;

endmodule
